// File: rtl/glonass_prn_pkg.sv
// Shared constants and types for the GLONASS ranging-code (x^9+x^5+1) receive-side synchroniser.
package glonass_prn_pkg;

  localparam int PRN_N       = 9;
  localparam int PRN_PERIOD  = 511;
  localparam int PRN_TAP_A   = 9;
  localparam int PRN_TAP_B   = 5;
  localparam int PRN_OUT_TAP = 7;

  // Window as w[1]..w[9], w[1] (newest chip) in the MSB.
  localparam logic [PRN_N-1:0] PRN_EPOCH_WIN   = 9'b001111111;
  localparam logic [8:0]       PRN_EPOCH_PHASE = 9'd8;

  typedef enum logic [1:0] {
    SYNC_FILL   = 2'd0,
    SYNC_VERIFY = 2'd1,
    SYNC_LOCKED = 2'd2
  } sync_state_e;

  function automatic logic [8:0] phase_inc(input logic [8:0] p);
    return (p == 9'(PRN_PERIOD - 1)) ? 9'd0 : p + 9'd1;
  endfunction

endpackage

// File: rtl/prn_phase_counter.sv
// Modulo-511 code-phase counter with synchronous load and count enable.
module prn_phase_counter
  import glonass_prn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [8:0] load_val_i,
  output logic [8:0] phase_o
);

  logic [8:0] cnt_q;
  logic [8:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = phase_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_o = cnt_q;

endmodule

// File: rtl/glonass_prn_sync.sv
// Self-synchronising receiver for the 511-chip GLONASS ranging code: acquires lock,
// flywheels through chip errors and recovers the code phase of each output chip.
module glonass_prn_sync
  import glonass_prn_pkg::*;
#(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chip_valid,
  input  logic       chip_in,
  output logic       chip_out_valid,
  output logic       chip_out,
  output logic       mismatch,
  output logic       locked,
  output logic [8:0] phase,
  output logic       phase_valid,
  output logic       epoch
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int EW = $clog2(LOSS_CNT + 1);

  sync_state_e   state_q, state_d;
  logic [1:9]    w_q, w_d;
  logic [3:0]    fill_q, fill_d;
  logic [MW-1:0] match_q, match_d;
  logic [EW-1:0] err_q, err_d;
  logic          pv_q, pv_d;
  logic          cov_q, co_q, co_d, mm_q, mm_d, lk_q, lk_d, ep_q, ep_d;

  logic          pred;
  logic          shift_in;
  logic          win_full;
  logic          enter_fill;
  logic          load_ph;
  logic          en_ph;

  assign pred = w_q[PRN_TAP_A] ^ w_q[PRN_TAP_B];

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    fill_d     = fill_q;
    match_d    = match_q;
    err_d      = err_q;
    pv_d       = pv_q;
    co_d       = co_q;
    mm_d       = 1'b0;
    ep_d       = 1'b0;
    lk_d       = lk_q;
    shift_in   = 1'b0;
    win_full   = 1'b0;
    enter_fill = 1'b0;
    load_ph    = 1'b0;
    en_ph      = 1'b0;

    if (chip_valid) begin
      // Once locked the window free-runs on its own prediction, so bad chips never enter it.
      shift_in = (state_q == SYNC_LOCKED) ? pred : chip_in;
      w_d      = {shift_in, w_q[1:8]};
      co_d     = shift_in;

      case (state_q)
        SYNC_FILL: begin
          fill_d = fill_q + 4'd1;
          if (fill_q == 4'(PRN_N - 1)) begin
            win_full = 1'b1;
            if (w_d != '0) begin
              state_d = SYNC_VERIFY;
              match_d = '0;
            end else begin
              fill_d = '0;
            end
          end
        end
        SYNC_VERIFY: begin
          win_full = 1'b1;
          if (chip_in == pred) begin
            match_d = match_q + 1'b1;
            if (match_d == MW'(LOCK_CNT)) begin
              state_d = SYNC_LOCKED;
              err_d   = '0;
            end
          end else begin
            mm_d       = 1'b1;
            state_d    = SYNC_FILL;
            fill_d     = '0;
            enter_fill = 1'b1;
          end
        end
        SYNC_LOCKED: begin
          if (chip_in != pred) begin
            mm_d  = 1'b1;
            err_d = err_q + 1'b1;
            if (err_d == EW'(LOSS_CNT)) begin
              state_d    = SYNC_FILL;
              fill_d     = '0;
              enter_fill = 1'b1;
            end
          end else begin
            err_d = '0;
          end
        end
        default: begin
          state_d    = SYNC_FILL;
          fill_d     = '0;
          enter_fill = 1'b1;
        end
      endcase

      load_ph = win_full && (w_d == PRN_EPOCH_WIN) && !enter_fill;
      en_ph   = pv_q;
      pv_d    = enter_fill ? 1'b0 : (load_ph ? 1'b1 : pv_q);
      ep_d    = pv_d && !load_ph && (phase == 9'(PRN_PERIOD - 1));
      lk_d    = (state_d == SYNC_LOCKED);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SYNC_FILL;
      w_q     <= '0;
      fill_q  <= '0;
      match_q <= '0;
      err_q   <= '0;
      pv_q    <= 1'b0;
      cov_q   <= 1'b0;
      co_q    <= 1'b0;
      mm_q    <= 1'b0;
      lk_q    <= 1'b0;
      ep_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      err_q   <= err_d;
      pv_q    <= pv_d;
      cov_q   <= chip_valid;
      co_q    <= co_d;
      mm_q    <= mm_d;
      lk_q    <= lk_d;
      ep_q    <= ep_d;
    end
  end

  prn_phase_counter u_phase (
    .clk        (clk),
    .rst        (reset),
    .load_i     (load_ph),
    .en_i       (en_ph),
    .load_val_i (PRN_EPOCH_PHASE),
    .phase_o    (phase)
  );

  assign chip_out_valid = cov_q;
  assign chip_out       = co_q;
  assign mismatch       = mm_q;
  assign locked         = lk_q;
  assign phase_valid    = pv_q;
  assign epoch          = ep_q;

endmodule

// File: tb/tb_glonass_prn_sync.sv
// Scoreboard bench for glonass_prn_sync: a behavioural receiver model predicts every output chip.
`timescale 1ns/1ps
module tb_glonass_prn_sync;

  localparam int LOCK_N = 16;
  localparam int LOSS_N = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       chip_valid;
  logic       chip_in;
  logic       chip_out_valid;
  logic       chip_out;
  logic       mismatch;
  logic       locked;
  logic [8:0] phase;
  logic       phase_valid;
  logic       epoch;

  glonass_prn_sync #(.LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N)) dut (
    .clk            (clk),
    .reset          (reset),
    .chip_valid     (chip_valid),
    .chip_in        (chip_in),
    .chip_out_valid (chip_out_valid),
    .chip_out       (chip_out),
    .mismatch       (mismatch),
    .locked         (locked),
    .phase          (phase),
    .phase_valid    (phase_valid),
    .epoch          (epoch)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit co;
    bit mm;
    bit lk;
    int ph;
    bit pv;
    bit ep;
    int idx;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   gen[0:510];

  // Reference receiver state
  int m_mode;   // 0 fill, 1 verify, 2 locked
  bit m_win[1:9];
  int m_fill, m_run, m_err, m_phase;
  bit m_pv;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void ref_reset();
    m_mode = 0; m_fill = 0; m_run = 0; m_err = 0; m_phase = 0; m_pv = 0;
    for (int i = 1; i <= 9; i++) m_win[i] = 0;
  endfunction

  function automatic exp_t ref_step(input bit c);
    exp_t e;
    bit pred, nb, zero, ewin, full, to_fill;
    pred = m_win[9] ^ m_win[5];
    nb   = (m_mode == 2) ? pred : c;
    e.co = nb;
    e.mm = (m_mode != 0) && (c != pred);
    for (int i = 9; i >= 2; i--) m_win[i] = m_win[i-1];
    m_win[1] = nb;
    zero = 1;
    for (int i = 1; i <= 9; i++) if (m_win[i]) zero = 0;
    ewin = !m_win[1] && !m_win[2];
    for (int i = 3; i <= 9; i++) if (!m_win[i]) ewin = 0;
    full = 0; to_fill = 0;
    if (m_mode == 0) begin
      m_fill++;
      if (m_fill == 9) begin
        full = 1;
        if (!zero) begin m_mode = 1; m_run = 0; end
        else m_fill = 0;
      end
    end else if (m_mode == 1) begin
      full = 1;
      if (c == pred) begin
        m_run++;
        if (m_run == LOCK_N) begin m_mode = 2; m_err = 0; end
      end else begin
        m_mode = 0; m_fill = 0; to_fill = 1;
      end
    end else begin
      if (c != pred) begin
        m_err++;
        if (m_err == LOSS_N) begin m_mode = 0; m_fill = 0; to_fill = 1; end
      end else m_err = 0;
    end
    if (to_fill) m_pv = 0;
    else if (full && ewin) begin m_phase = 8; m_pv = 1; end
    else if (m_pv) m_phase = (m_phase + 1) % 511;
    e.lk  = (m_mode == 2);
    e.pv  = m_pv;
    e.ph  = m_phase;
    e.ep  = m_pv && (m_phase == 0);
    e.idx = -1;
    return e;
  endfunction

  task automatic send(input bit c, input int idx, input int gap);
    exp_t e;
    e = ref_step(c);
    e.idx = idx;
    sbq.push_back(e);
    chip_in = c;
    chip_valid = 1'b1;
    @(posedge clk); #1;
    chip_valid = 1'b0;
    chip_in = 1'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cov"}, chip_out_valid, 0);
    check({tag, "_co"}, chip_out, 0);
    check({tag, "_mm"}, mismatch, 0);
    check({tag, "_lk"}, locked, 0);
    check({tag, "_ph"}, phase, 0);
    check({tag, "_pv"}, phase_valid, 0);
    check({tag, "_ep"}, epoch, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check_zero(tag);
    ref_reset();
    sbq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: one expected entry per presented output chip
  exp_t me;
  always @(negedge clk) begin
    if (!reset) begin
      if (chip_out_valid) begin
        if (sbq.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          me = sbq.pop_front();
          check("chip_out", chip_out, me.co);
          check("mismatch", mismatch, me.mm);
          check("locked", locked, me.lk);
          check("phase_valid", phase_valid, me.pv);
          check("epoch", epoch, me.ep);
          if (me.pv) check("phase", phase, me.ph);
          if (me.pv && me.idx >= 0) check("phase_vs_gen", phase, me.idx % 511);
        end
      end else begin
        check("idle_mismatch", mismatch, 0);
        check("idle_epoch", epoch, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired sbq=%0d required=0", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    bit c;
    reset = 1'b1;
    chip_valid = 1'b0;
    chip_in = 1'b0;
    for (int i = 0; i < 7; i++) gen[i] = 1;
    gen[7] = 0;
    gen[8] = 0;
    for (int n = 9; n < 511; n++) gen[n] = gen[n-9] ^ gen[n-5];
    ref_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // Clean stream from generator reset, then single and triple chip errors while locked
    for (int n = 0; n < 1400; n++) begin
      c = gen[n % 511];
      if (n == 1150 || (n >= 1320 && n <= 1322)) c = ~c;
      send(c, n, 0);
    end

    do_reset("rst_t4");
    for (int n = 0; n < 2000; n++) send(1'b0, -1, 0);

    do_reset("rst_t5");
    for (int n = 0; n < 1100; n++) send(gen[n % 511], n, 2);

    do_reset("rst_t6a");
    for (int n = 0; n < 100; n++) send(gen[n % 511], n, 0);
    do_reset("rst_locked");
    for (int n = 0; n < 600; n++) send(gen[n % 511], n, 0);

    // Random entry point, random gaps, sparse random chip errors
    do_reset("rst_rand");
    start = $urandom_range(0, 510);
    for (int n = 0; n < 2500; n++) begin
      c = gen[(start + n) % 511];
      if ($urandom_range(0, 39) == 0) c = ~c;
      send(c, -1, $urandom_range(0, 2));
    end
    for (int n = 0; n < 300; n++) send(1'($urandom), -1, $urandom_range(0, 1));

    repeat (5) @(posedge clk);
    check("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
